// File: rtl/stim_gen_lfsr.sv
// stim_gen_lfsr: multi-channel pseudorandom stimulus generator.
// Each channel owns a 32-bit Galois LFSR; vectors leave on a valid/ready
// handshake with programmable vector count and inter-vector hold gap.
// Optional build macro STIM_GEN_CHECKSUM_EN adds a running XOR checksum
// of every accepted vector (all channels, full 32-bit LFSR words).

module stim_gen_lfsr #(
    parameter int          NUM_CH = 4,
    parameter int          DATA_W = 32,
    parameter int          CNT_W  = 16,
    parameter int          HOLD_W = 8,
    parameter logic [31:0] SEED   = 32'h0000ACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     seed_load,
    input  logic [31:0]              seed_val,
    input  logic [CNT_W-1:0]         num_vectors,
    input  logic [HOLD_W-1:0]        hold_cycles,
    input  logic                     stim_ready,
    output logic [NUM_CH*DATA_W-1:0] stim_data,
    output logic                     stim_valid,
    output logic                     busy,
    output logic                     done,
`ifdef STIM_GEN_CHECKSUM_EN
    output logic [31:0]              checksum,
`endif
    output logic [CNT_W-1:0]         vec_count
);

    localparam logic [31:0] POLY = 32'h80200003;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Per-channel seed; an all-zero LFSR would lock up, so zero becomes 1.
    function automatic logic [31:0] ch_seed(input logic [31:0] base, input int ch);
        logic [31:0] s;
        s = base ^ (32'(ch) << 24);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    // One Galois step: shift right, fold the polynomial in when lsb was set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    state_t              state_q,     state_d;
    logic [31:0]         lfsr_q [NUM_CH];
    logic [31:0]         lfsr_d [NUM_CH];
    logic                valid_q,     valid_d;
    logic                done_q,      done_d;
    logic [CNT_W-1:0]    vec_count_q, vec_count_d;
    logic [CNT_W-1:0]    num_vec_q,   num_vec_d;
    logic [HOLD_W-1:0]   hold_cfg_q,  hold_cfg_d;
    logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
`ifdef STIM_GEN_CHECKSUM_EN
    logic [31:0]         csum_q,      csum_d;
    logic [31:0]         vec_xor;
`endif

    logic                accept;
    logic [CNT_W-1:0]    cnt_inc;

    assign accept  = valid_q & stim_ready;
    assign cnt_inc = vec_count_q + CNT_W'(1);

`ifdef STIM_GEN_CHECKSUM_EN
    // XOR of all channel words of the vector currently presented.
    always_comb begin
        vec_xor = 32'd0;
        for (int i = 0; i < NUM_CH; i++) vec_xor = vec_xor ^ lfsr_q[i];
    end
`endif

    // Next-state logic for the FSM, LFSRs, counters and handshake.
    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        valid_d     = valid_q;
        done_d      = done_q;
        vec_count_d = vec_count_q;
        num_vec_d   = num_vec_q;
        hold_cfg_d  = hold_cfg_q;
        hold_cnt_d  = hold_cnt_q;
        for (int i = 0; i < NUM_CH; i++) lfsr_d[i] = lfsr_q[i];
`ifdef STIM_GEN_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (stop && state_q == S_DONE) begin
                    // Abort from DONE also wins over a coincident start.
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end else if (!stop) begin
                    // Seed first so a same-cycle start presents the new seed.
                    if (seed_load) begin
                        for (int i = 0; i < NUM_CH; i++) lfsr_d[i] = ch_seed(seed_val, i);
                    end
                    if (start) begin
                        state_d     = S_RUN;
                        valid_d     = 1'b1;
                        done_d      = 1'b0;
                        vec_count_d = '0;
                        num_vec_d   = num_vectors;
                        hold_cfg_d  = hold_cycles;
`ifdef STIM_GEN_CHECKSUM_EN
                        csum_d      = 32'd0;
`endif
                    end
                end
            end

            S_RUN: begin
                if (accept) begin
                    for (int i = 0; i < NUM_CH; i++) lfsr_d[i] = lfsr_step(lfsr_q[i]);
                    vec_count_d = cnt_inc;
`ifdef STIM_GEN_CHECKSUM_EN
                    csum_d      = csum_q ^ vec_xor;
`endif
                    if (stop) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end else if (num_vec_q != '0 && cnt_inc == num_vec_q) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (hold_cfg_q != '0) begin
                        state_d    = S_HOLD;
                        valid_d    = 1'b0;
                        hold_cnt_d = hold_cfg_q;
                    end
                end else if (stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (hold_cnt_q == HOLD_W'(1)) begin
                    state_d = S_RUN;
                    valid_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; async reset returns every LFSR to its default seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            vec_count_q <= '0;
            num_vec_q   <= '0;
            hold_cfg_q  <= '0;
            hold_cnt_q  <= '0;
            // NOTE: the LFSR array is reset like any other register because
            // its reset contents are architecturally visible on stim_data.
            for (int i = 0; i < NUM_CH; i++) lfsr_q[i] <= ch_seed(SEED, i);
`ifdef STIM_GEN_CHECKSUM_EN
            csum_q      <= 32'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            vec_count_q <= vec_count_d;
            num_vec_q   <= num_vec_d;
            hold_cfg_q  <= hold_cfg_d;
            hold_cnt_q  <= hold_cnt_d;
            for (int i = 0; i < NUM_CH; i++) lfsr_q[i] <= lfsr_d[i];
`ifdef STIM_GEN_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Channel outputs are the low DATA_W bits of each LFSR, in every state.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign stim_data[g*DATA_W +: DATA_W] = lfsr_q[g][DATA_W-1:0];
    end

    assign stim_valid = valid_q;
    assign done       = done_q;
    assign vec_count  = vec_count_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_HOLD);
`ifdef STIM_GEN_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule
